// File: rtl/sbm_digitized_div.sv
// sbm_digitized_div: digit-serial restoring divider.
// Divides a 2*SIZEA-bit dividend by a SIZEA-bit divisor. It produces one quotient
// bit per cycle and groups the bits into SIZEOF_DIGITS-bit digits, MSB digit first.
// DIGITS * SIZEOF_DIGITS must equal SIZEA.
// Optional feature macro: SBM_DIV_OVF_CHECK_EN. When it is defined, divide-by-zero
// and quotient overflow are detected on acceptance and the result is returned at once.
module sbm_digitized_div #(
    parameter int SIZEA         = 32,
    parameter int SIZEOF_DIGITS = 4,
    parameter int DIGITS        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*SIZEA-1:0]   n,
    input  logic [SIZEA-1:0]     d,
    output logic                 busy,
    output logic                 done,
    output logic [SIZEA-1:0]     q,
    output logic [SIZEA-1:0]     r,
    output logic                 ovf
);

    localparam int BW = (SIZEOF_DIGITS > 1) ? $clog2(SIZEOF_DIGITS) : 1;
    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [BW-1:0] LAST_BIT   = BW'(SIZEOF_DIGITS - 1);
    localparam logic [KW-1:0] LAST_DIGIT = KW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BIT,
        COMMIT
    } state_t;

    state_t state, state_next;

    logic [SIZEA-1:0]         d_reg;
    logic [SIZEA-1:0]         n_lo;
    logic [SIZEA:0]           pr;
    logic [SIZEOF_DIGITS-1:0] digit;
    logic [SIZEA-1:0]         q_acc;
    logic [BW-1:0]            bit_cnt;
    logic [KW-1:0]            dig_cnt;
    logic [SIZEA-1:0]         q_reg;
    logic [SIZEA-1:0]         r_reg;
    logic                     done_reg;

    logic [SIZEA:0]           pr_shift;
    logic                     ge;
    logic [SIZEA:0]           pr_step;
    logic [SIZEA-1:0]         q_merged;
    logic                     ovf_hit;
    logic                     last_commit;

`ifdef SBM_DIV_OVF_CHECK_EN
    logic                     ovf_reg;
    assign ovf_hit = (d == '0) || (n[2*SIZEA-1:SIZEA] >= d);
    assign ovf     = ovf_reg;
`else
    assign ovf_hit = 1'b0;
    assign ovf     = 1'b0;
`endif

    assign busy        = (state != IDLE);
    assign done        = done_reg;
    assign q           = q_reg;
    assign r           = r_reg;
    assign last_commit = (state == COMMIT) && (dig_cnt == LAST_DIGIT);

    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits
    always_comb begin
        pr_shift = {pr[SIZEA-1:0], n_lo[SIZEA-1]};
        ge       = (pr_shift >= {1'b0, d_reg});
        pr_step  = ge ? (pr_shift - {1'b0, d_reg}) : pr_shift;
    end

    // Place the finished digit into its slot of the quotient, MSB digit first
    always_comb begin
        q_merged = q_acc;
        q_merged[(DIGITS - 1 - int'(dig_cnt)) * SIZEOF_DIGITS +: SIZEOF_DIGITS] = digit;
    end

    // State register; a synchronous reset aborts any division in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: SIZEOF_DIGITS BIT cycles per digit, then one COMMIT cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !ovf_hit) begin
                    state_next = BIT;
                end
            end
            BIT: begin
                if (bit_cnt == LAST_BIT) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                if (dig_cnt == LAST_DIGIT) begin
                    state_next = IDLE;
                end else begin
                    state_next = BIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands, iterate the remainder, collect digits, publish results
    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg    <= '0;
            n_lo     <= '0;
            pr       <= '0;
            digit    <= '0;
            q_acc    <= '0;
            bit_cnt  <= '0;
            dig_cnt  <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (ovf_hit) begin
                            q_reg    <= '1;
                            r_reg    <= '0;
                            done_reg <= 1'b1;
                        end else begin
                            d_reg   <= d;
                            n_lo    <= n[SIZEA-1:0];
                            pr      <= {1'b0, n[2*SIZEA-1:SIZEA]};
                            digit   <= '0;
                            q_acc   <= '0;
                            bit_cnt <= '0;
                            dig_cnt <= '0;
                        end
                    end
                end
                BIT: begin
                    pr      <= pr_step;
                    n_lo    <= n_lo << 1;
                    digit   <= (digit << 1) | SIZEOF_DIGITS'(ge);
                    bit_cnt <= bit_cnt + 1'b1;
                end
                COMMIT: begin
                    q_acc   <= q_merged;
                    dig_cnt <= dig_cnt + 1'b1;
                    bit_cnt <= '0;
                    if (dig_cnt == LAST_DIGIT) begin
                        q_reg    <= q_merged;
                        r_reg    <= pr[SIZEA-1:0];
                        done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SBM_DIV_OVF_CHECK_EN
    // Overflow flag: set by the early-exit path, cleared by the next normal completion
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if ((state == IDLE) && start && ovf_hit) begin
            ovf_reg <= 1'b1;
        end else if (last_commit) begin
            ovf_reg <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sbm_digitized_div.sv
// tb_sbm_digitized_div: scoreboard bench for sbm_digitized_div.
// Expected results are queued when a request is driven. They are compared when done pulses.
// The optional SBM_DIV_OVF_CHECK_EN macro selects the matching overflow expectations.
module tb_sbm_digitized_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] n;
    logic [31:0] d;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        ovf;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cycle  = 0;
    int   checks = 0;
    int   fails  = 0;

    sbm_digitized_div #(
        .SIZEA(32),
        .SIZEOF_DIGITS(4),
        .DIGITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .n(n),
        .d(d),
        .busy(busy),
        .done(done),
        .q(q),
        .r(r),
        .ovf(ovf)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to check done latency
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge while the DUT is idle; returns just after the accepting edge
    task automatic applyStimulus(input logic [63:0] nv, input logic [31:0] dv,
                                 input logic [31:0] eq, input logic [31:0] er,
                                 input logic eo, input int lat);
        exp_t x;
        start = 1'b1;
        n     = nv;
        d     = dv;
        @(posedge clk);
        #1;
        x.q   = eq;
        x.r   = er;
        x.ovf = eo;
        x.cyc = cycle + lat;
        sb.push_back(x);
        start = 1'b0;
    endtask

    // Returns on the negedge where done is seen, or records a timeout
    task automatic waitDone(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < budget);
        checkOutput("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic runDiv(input logic [63:0] nv, input logic [31:0] dv);
        logic [63:0] qq;
        logic [63:0] rr;
        qq = nv / {32'd0, dv};
        rr = nv % {32'd0, dv};
        applyStimulus(nv, dv, qq[31:0], rr[31:0], 1'b0, 40);
        waitDone(60);
    endtask

    // Scoreboard monitor: every done must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            checkOutput("done_expected", {63'd0, (sb.size() != 0)}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("q", {32'd0, q}, {32'd0, e.q});
                checkOutput("r", {32'd0, r}, {32'd0, e.r});
                checkOutput("ovf", {63'd0, ovf}, {63'd0, e.ovf});
                checkOutput("done_cycle", 64'(cycle), 64'(e.cyc));
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus sequence followed by a random sweep
    initial begin
        logic [31:0] rd;
        logic [31:0] rh;

        rst   = 1'b1;
        start = 1'b0;
        n     = '0;
        d     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_q", {32'd0, q}, 64'd0);
        checkOutput("rst_r", {32'd0, r}, 64'd0);
        checkOutput("rst_ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 100 / 7 with busy/done timing
        applyStimulus(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 40);
        for (int i = 0; i < 40; i++) begin
            checkOutput("busy_during", {63'd0, busy}, 64'd1);
            checkOutput("done_early", {63'd0, done}, 64'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("busy_at_done", {63'd0, busy}, 64'd0);
        checkOutput("done_at_e40", {63'd0, done}, 64'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("done_pulse", {63'd0, done}, 64'd0);
        @(negedge clk);

        runDiv(64'hFFFFFFFE_00000001, 32'hFFFFFFFF);
        runDiv(64'h00000000_FFFFFFFF, 32'd1);
        // back-to-back: start in the done cycle
        runDiv(64'h00000005_00000000, 32'h10);
        @(negedge clk);

`ifdef SBM_DIV_OVF_CHECK_EN
        applyStimulus(64'd5, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 0);
        waitDone(5);
        checkOutput("ovf_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        applyStimulus(64'h00000010_00000000, 32'h10, 32'hFFFFFFFF, 32'd0, 1'b1, 0);
        waitDone(5);
        @(negedge clk);
        runDiv(64'd100, 32'd7);
        @(negedge clk);
`else
        applyStimulus(64'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b0, 40);
        waitDone(60);
        @(negedge clk);
`endif

        // extra start pulses during a division are ignored
        applyStimulus(64'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 40);
        repeat (4) @(negedge clk);
        start = 1'b1;
        n     = 64'd999;
        d     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(60);
        repeat (45) @(negedge clk);
        checkOutput("no_extra_done", 64'(sb.size()), 64'd0);

        // reset in the middle of a division
        applyStimulus(64'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0, 40);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_done", {63'd0, done}, 64'd0);
        checkOutput("abort_q", {32'd0, q}, 64'd0);
        checkOutput("abort_r", {32'd0, r}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (45) @(negedge clk);
        runDiv(64'd123456789, 32'd1000);
        @(negedge clk);

        // random sweep with n[63:32] < d != 0
        for (int i = 0; i < 200; i++) begin
            rd = $urandom;
            if (rd == 32'd0) rd = 32'd1;
            rh = $urandom_range(rd - 32'd1, 0);
            runDiv({rh, 32'($urandom)}, rd);
        end
        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
